// File: rtl/bin2ascii_seq_if.sv
// Handshake bundle for bin2ascii_seq: binary sample in, ASCII result out.
// master: the side that supplies bin_in and consumes the result.
// slave:  the converter itself.
interface bin2ascii_seq_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4,
    parameter int SIGNED = 0
);
    logic [BIN_W-1:0]                bin_in;
    logic                            in_valid;
    logic                            in_ready;
    logic [8*(DIGITS+SIGNED)-1:0]    ascii_out;
    logic                            ovf;
    logic                            out_valid;
    logic                            out_ready;

    modport master (
        output bin_in, in_valid, out_ready,
        input  in_ready, ascii_out, ovf, out_valid
    );

    modport slave (
        input  bin_in, in_valid, out_ready,
        output in_ready, ascii_out, ovf, out_valid
    );
endinterface

// File: rtl/bin2ascii_seq.sv
// Sequential binary-to-ASCII-decimal converter (shift-and-add-3 / double dabble).
// One ADD + one SHIFT state per input bit, then CONV formats the characters and
// OUT holds them until the sink takes them.
// Optional build macro BIN2ASCII_LZ_BLANK_EN: leading zero digits become spaces
// (least-significant digit always shown, no blanking when ovf is set).
module bin2ascii_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4,
    parameter int SIGNED = 0
) (
    input  logic           clk,
    input  logic           rst,
    bin2ascii_seq_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int OUT_W = 8 * (DIGITS + SIGNED);
    localparam int CNT_W = $clog2(BIN_W);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StAdd   = 3'd1;
    localparam logic [2:0] StShift = 3'd2;
    localparam logic [2:0] StConv  = 3'd3;
    localparam logic [2:0] StOut   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic [OUT_W-1:0] ascii_q, ascii_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [BIN_W-1:0]    magnitude;
    logic [BCD_W-1:0]    bcd_adj;
    logic [8*DIGITS-1:0] digit_chars;
    logic [OUT_W-1:0]    conv_word;
`ifdef BIN2ASCII_LZ_BLANK_EN
    logic                lz_blank;
`endif

    assign bus.in_ready  = (state_q == StIdle) & ~rst;
    assign bus.ascii_out = ascii_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = out_valid_q;

    // Unsigned magnitude of the incoming sample; -2^(BIN_W-1) maps to 2^(BIN_W-1)
    always_comb begin
        magnitude = bus.bin_in;
        if (SIGNED != 0 && bus.bin_in[BIN_W-1]) begin
            magnitude = -bus.bin_in;
        end
    end

    // Add-3 correction applied to every BCD nibble in parallel (4-bit wrap)
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] > 4'd4) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Digit characters, most significant first so blanking can stop at the first non-zero
    always_comb begin
`ifdef BIN2ASCII_LZ_BLANK_EN
        lz_blank = ~sticky_q;
`endif
        digit_chars = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            digit_chars[8*i +: 8] = {4'h3, bcd_q[4*i +: 4]};
`ifdef BIN2ASCII_LZ_BLANK_EN
            if (lz_blank && i != 0 && bcd_q[4*i +: 4] == 4'd0) begin
                digit_chars[8*i +: 8] = 8'h20;
            end else begin
                lz_blank = 1'b0;
            end
`endif
        end
    end

    if (SIGNED != 0) begin : g_sign
        logic neg_q;

        // Remember whether the accepted sample was negative
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                neg_q <= 1'b0;
            end else if (state_q == StIdle && bus.in_valid) begin
                neg_q <= bus.bin_in[BIN_W-1];
            end
        end

        assign conv_word = {(neg_q ? 8'h2D : 8'h20), digit_chars};
    end else begin : g_nosign
        assign conv_word = digit_chars;
    end

    // Next-state logic for the conversion sequencer
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        ascii_d     = ascii_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    bin_d    = magnitude;
                    bcd_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = StAdd;
                end
            end
            StAdd: begin
                bcd_d   = bcd_adj;
                state_d = StShift;
            end
            StShift: begin
                {bcd_d, bin_d} = {bcd_q, bin_q} << 1;
                // Anything leaving the top digit means the value needs more digits
                sticky_d = sticky_q | bcd_q[BCD_W-1];
                cnt_d    = cnt_q + 1'b1;
                state_d  = (cnt_q == CNT_W'(BIN_W - 1)) ? StConv : StAdd;
            end
            StConv: begin
                ascii_d     = conv_word;
                ovf_d       = sticky_q;
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset aborts any conversion in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            ascii_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            ascii_q     <= ascii_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_bin2ascii_seq.sv
// Directed bench for bin2ascii_seq: a default unsigned 14-bit/4-digit instance and
// a signed 8-bit/3-digit instance. Honours BIN2ASCII_LZ_BLANK_EN for expectations.
module tb_bin2ascii_seq;
    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    bin2ascii_seq_if #(.BIN_W(14), .DIGITS(4), .SIGNED(0)) a_if ();
    bin2ascii_seq_if #(.BIN_W(8),  .DIGITS(3), .SIGNED(1)) b_if ();

    bin2ascii_seq #(.BIN_W(14), .DIGITS(4), .SIGNED(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    bin2ascii_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

`ifdef BIN2ASCII_LZ_BLANK_EN
    localparam logic [31:0] A_ZERO = 32'h20202030;
    localparam logic [31:0] A_500  = 32'h20353030;
    localparam logic [31:0] A_77   = 32'h20203737;
    localparam logic [31:0] B_M1   = 32'h2D202031;
`else
    localparam logic [31:0] A_ZERO = 32'h30303030;
    localparam logic [31:0] A_500  = 32'h30353030;
    localparam logic [31:0] A_77   = 32'h30303737;
    localparam logic [31:0] B_M1   = 32'h2D303031;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_a(input logic [13:0] val, input logic [31:0] exp_ascii,
                         input logic exp_ovf, input string tag);
        int n;
        n = 0;
        while (a_if.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " in_ready"}, 64'(a_if.in_ready), 64'd1);
        a_if.bin_in    = val;
        a_if.in_valid  = 1'b1;
        a_if.out_ready = 1'b1;
        @(posedge clk); #1;
        a_if.in_valid = 1'b0;
        n = 0;
        while (a_if.out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " latency"}, 64'(n), 64'd29);
        check({tag, " ascii"}, 64'(a_if.ascii_out), 64'(exp_ascii));
        check({tag, " ovf"}, 64'(a_if.ovf), 64'(exp_ovf));
        @(posedge clk); #1;
        check({tag, " out_valid one cycle"}, 64'(a_if.out_valid), 64'd0);
    endtask

    task automatic run_b(input logic [7:0] val, input logic [31:0] exp_ascii, input string tag);
        int n;
        n = 0;
        while (b_if.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " in_ready"}, 64'(b_if.in_ready), 64'd1);
        b_if.bin_in    = val;
        b_if.in_valid  = 1'b1;
        b_if.out_ready = 1'b1;
        @(posedge clk); #1;
        b_if.in_valid = 1'b0;
        n = 0;
        while (b_if.out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " latency"}, 64'(n), 64'd17);
        check({tag, " ascii"}, 64'(b_if.ascii_out), 64'(exp_ascii));
        check({tag, " ovf"}, 64'(b_if.ovf), 64'd0);
        @(posedge clk); #1;
        check({tag, " out_valid one cycle"}, 64'(b_if.out_valid), 64'd0);
    endtask

    initial begin
        int n;
        rst            = 1'b1;
        a_if.bin_in    = '0;
        a_if.in_valid  = 1'b0;
        a_if.out_ready = 1'b0;
        b_if.bin_in    = '0;
        b_if.in_valid  = 1'b0;
        b_if.out_ready = 1'b0;
        #2;
        check("rst a in_ready", 64'(a_if.in_ready), 64'd0);
        check("rst a ascii", 64'(a_if.ascii_out), 64'd0);
        check("rst a ovf", 64'(a_if.ovf), 64'd0);
        check("rst a out_valid", 64'(a_if.out_valid), 64'd0);
        check("rst b in_ready", 64'(b_if.in_ready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("post-rst a in_ready", 64'(a_if.in_ready), 64'd1);

        run_a(14'd9999, 32'h39393939, 1'b0, "a_9999");
        run_a(14'd0, A_ZERO, 1'b0, "a_0");
        run_a(14'd16383, 32'h36333833, 1'b1, "a_16383");

        run_b(8'h80, 32'h2D313238, "b_m128");
        run_b(8'h7F, 32'h20313237, "b_127");
        run_b(8'hFF, B_M1, "b_m1");

        // Backpressure: result held while the sink stalls, new request ignored
        a_if.bin_in    = 14'd500;
        a_if.in_valid  = 1'b1;
        a_if.out_ready = 1'b0;
        @(posedge clk); #1;
        a_if.in_valid = 1'b0;
        n = 0;
        while (a_if.out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("bp latency", 64'(n), 64'd29);
        a_if.bin_in   = 14'd77;
        a_if.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp out_valid held", 64'(a_if.out_valid), 64'd1);
            check("bp ascii held", 64'(a_if.ascii_out), 64'(A_500));
            check("bp in_ready low", 64'(a_if.in_ready), 64'd0);
        end
        a_if.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp handshake out_valid", 64'(a_if.out_valid), 64'd0);
        check("bp handshake in_ready", 64'(a_if.in_ready), 64'd1);
        check("bp ascii retained", 64'(a_if.ascii_out), 64'(A_500));
        @(posedge clk); #1;
        a_if.in_valid = 1'b0;
        check("bp new accept", 64'(a_if.in_ready), 64'd0);
        n = 0;
        while (a_if.out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("bp2 latency", 64'(n), 64'd29);
        check("bp2 ascii", 64'(a_if.ascii_out), 64'(A_77));
        check("bp2 ovf", 64'(a_if.ovf), 64'd0);
        @(posedge clk); #1;

        // Reset in the middle of a conversion
        a_if.bin_in   = 14'd4321;
        a_if.in_valid = 1'b1;
        @(posedge clk); #1;
        a_if.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid-rst out_valid", 64'(a_if.out_valid), 64'd0);
        check("mid-rst ascii", 64'(a_if.ascii_out), 64'd0);
        check("mid-rst ovf", 64'(a_if.ovf), 64'd0);
        check("mid-rst in_ready", 64'(a_if.in_ready), 64'd0);
        check("mid-rst b ascii", 64'(b_if.ascii_out), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("after-rst in_ready", 64'(a_if.in_ready), 64'd1);
        check("after-rst out_valid", 64'(a_if.out_valid), 64'd0);
        run_a(14'd1234, 32'h31323334, 1'b0, "a_1234");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
